// File: rtl/spi_shift_engine_pkg.sv
// spi_pkg: shared types and constants for the SPI shift engine slice.
//   spi_shift_state_t : frame state machine encoding
//   SPI_DATA_W_DEF    : default maximum frame width
//   spi_eff_len()     : maps a requested frame length onto the effective one
package spi_pkg;

  localparam int SPI_DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE,
    LOADED,
    SHIFT,
    DONE
  } spi_shift_state_t;

  // A request of 0, or anything wider than the engine, means a full-width frame.
  function automatic int unsigned spi_eff_len(input int unsigned req,
                                              input int unsigned max_len);
    return (req == 0 || req > max_len) ? max_len : req;
  endfunction

endpackage

// File: rtl/spi_shift_engine_if.sv
// spi_shift_engine_if: bus bundle between the SPI control/status logic,
// the baud generator and the shift engine.
//   slave  modport : the shift engine (config, strobes, serial in -> serial out, status)
//   master modport : the control side driving configuration and strobes
// Optional: SPI_SHIFT_LOOPBACK_EN adds the 'loopback' select.
interface spi_shift_engine_if
  import spi_pkg::*;
#(
  parameter int DATA_W = SPI_DATA_W_DEF,
  parameter int CNT_W  = $clog2(DATA_W + 1)
) ();

  logic              ss;
  logic              send_data;
  logic              lsbfe;
  logic              cpha;
  logic              cpol;
  logic              flag_high;
  logic              flag_low;
  logic              flags_high;
  logic              flags_low;
  logic [CNT_W-1:0]  frame_len;
  logic              miso;
  logic [DATA_W-1:0] data_mosi;
`ifdef SPI_SHIFT_LOOPBACK_EN
  logic              loopback;
`endif
  logic              mosi;
  logic [DATA_W-1:0] data_miso;
  logic              rx_valid;
  logic              busy;
  logic              frame_abort;

  modport slave (
    input  ss, send_data, lsbfe, cpha, cpol,
    input  flag_high, flag_low, flags_high, flags_low,
    input  frame_len, miso, data_mosi,
`ifdef SPI_SHIFT_LOOPBACK_EN
    input  loopback,
`endif
    output mosi, data_miso, rx_valid, busy, frame_abort
  );

  modport master (
    output ss, send_data, lsbfe, cpha, cpol,
    output flag_high, flag_low, flags_high, flags_low,
    output frame_len, miso, data_mosi,
`ifdef SPI_SHIFT_LOOPBACK_EN
    output loopback,
`endif
    input  mosi, data_miso, rx_valid, busy, frame_abort
  );

endinterface

// File: rtl/spi_shift_engine_bit_counter.sv
// spi_bit_counter: per-frame received-bit counter and latched frame length.
//   PCLK, PRESETn : clock, synchronous active-low reset
//   load          : start of frame; clears bit_cnt and latches len_in
//   inc           : one bit sampled
//   len_in        : effective frame length (already range-limited)
//   bit_cnt       : bits sampled so far in this frame
//   len           : latched frame length L
//   last_bit      : the next sample completes the frame
module spi_bit_counter
  import spi_pkg::*;
#(
  parameter int DATA_W = SPI_DATA_W_DEF,
  parameter int CNT_W  = $clog2(DATA_W + 1)
) (
  input  logic             PCLK,
  input  logic             PRESETn,
  input  logic             load,
  input  logic             inc,
  input  logic [CNT_W-1:0] len_in,
  output logic [CNT_W-1:0] bit_cnt,
  output logic [CNT_W-1:0] len,
  output logic             last_bit
);

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      bit_cnt <= '0;
      len     <= CNT_W'(DATA_W);
    end else if (load) begin
      bit_cnt <= '0;
      len     <= len_in;
    end else if (inc) begin
      bit_cnt <= bit_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    last_bit = (bit_cnt == len - CNT_W'(1));
  end

endmodule

// File: rtl/spi_shift_engine.sv
// spi_shift_engine: parametrised SPI data-path shift engine with a frame FSM.
//   PCLK, PRESETn : clock, synchronous active-low reset
//   bus (slave)   : ss, send_data, lsbfe, cpha, cpol, sample/shift strobes,
//                   frame_len, miso, data_mosi in; mosi, data_miso, rx_valid,
//                   busy, frame_abort out
// Optional: define SPI_SHIFT_LOOPBACK_EN to add bus.loopback, which feeds the
// registered mosi back into the receive path in place of miso.
module spi_shift_engine
  import spi_pkg::*;
#(
  parameter int DATA_W = SPI_DATA_W_DEF,
  parameter int CNT_W  = $clog2(DATA_W + 1)
) (
  input  logic          PCLK,
  input  logic          PRESETn,
  spi_shift_engine_if.slave bus
);

  spi_shift_state_t  state_q, state_d;

  logic [DATA_W-1:0] tx_q;
  logic [DATA_W-1:0] rx_q;
  logic [DATA_W-1:0] data_miso_q;
  logic              mosi_q;
  logic              abort_q;
  logic [CNT_W-1:0]  tx_cnt_q;

  logic              sample;
  logic              shift;
  logic              rx_in;
  logic [CNT_W-1:0]  load_len;
  logic [DATA_W-1:0] tx_load;
  logic              tx_first;
  logic [DATA_W-1:0] tx_next;
  logic              mosi_next;
  logic [DATA_W-1:0] rx_next;
  logic [DATA_W-1:0] rx_word;

  logic              load;
  logic              smp_en;
  logic              drv_en;
  logic              abort;
  logic              done;

  logic [CNT_W-1:0]  bit_cnt;
  logic [CNT_W-1:0]  len;
  logic              last_bit;

  spi_bit_counter #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_bit_counter (
    .PCLK     (PCLK),
    .PRESETn  (PRESETn),
    .load     (load),
    .inc      (smp_en),
    .len_in   (load_len),
    .bit_cnt  (bit_cnt),
    .len      (len),
    .last_bit (last_bit)
  );

  // Strobe selection and data-path next values.
  always_comb begin
    sample = (bus.cpha ^ bus.cpol) ? bus.flag_high  : bus.flag_low;
    shift  = (bus.cpha ^ bus.cpol) ? bus.flags_high : bus.flags_low;

`ifdef SPI_SHIFT_LOOPBACK_EN
    rx_in = bus.loopback ? mosi_q : bus.miso;
`else
    rx_in = bus.miso;
`endif

    load_len = CNT_W'(spi_eff_len(32'(bus.frame_len), 32'(DATA_W)));

    // MSB-first frames are pre-aligned so bit L-1 sits at the top of tx_q;
    // both orders then shift out from a fixed end of the register.
    if (bus.lsbfe) begin
      tx_load   = bus.data_mosi;
      tx_first  = bus.data_mosi[0];
      tx_next   = tx_q >> 1;
      mosi_next = tx_q[1];
      rx_next   = {rx_in, rx_q[DATA_W-1:1]};
      rx_word   = rx_next >> (CNT_W'(DATA_W) - len);
    end else begin
      tx_load   = bus.data_mosi << (CNT_W'(DATA_W) - load_len);
      tx_first  = tx_load[DATA_W-1];
      tx_next   = tx_q << 1;
      mosi_next = tx_q[DATA_W-2];
      rx_next   = {rx_q[DATA_W-2:0], rx_in};
      rx_word   = rx_next;
    end
  end

  // Frame FSM: next state and per-cycle controls.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    smp_en  = 1'b0;
    drv_en  = 1'b0;
    abort   = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.send_data) begin
          load    = 1'b1;
          state_d = LOADED;
        end
      end
      LOADED: begin
        if (bus.ss) begin
          abort   = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (bus.ss) begin
          abort   = 1'b1;
          state_d = IDLE;
        end else begin
          smp_en = sample;
          drv_en = shift && (tx_cnt_q < len);
          if (sample && last_bit) begin
            done    = 1'b1;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      tx_q        <= '0;
      rx_q        <= '0;
      data_miso_q <= '0;
      mosi_q      <= 1'b0;
      abort_q     <= 1'b0;
      tx_cnt_q    <= '0;
    end else begin
      abort_q <= abort;
      if (load) begin
        tx_q     <= tx_load;
        rx_q     <= '0;
        mosi_q   <= tx_first;
        tx_cnt_q <= CNT_W'(1);
      end
      if (drv_en) begin
        tx_q     <= tx_next;
        mosi_q   <= mosi_next;
        tx_cnt_q <= tx_cnt_q + CNT_W'(1);
      end
      if (smp_en) begin
        rx_q <= rx_next;
      end
      // The received word is committed on the final sample edge so that it is
      // visible during DONE, together with rx_valid.
      if (done) begin
        data_miso_q <= rx_word;
      end
    end
  end

  assign bus.mosi        = mosi_q;
  assign bus.data_miso   = data_miso_q;
  assign bus.rx_valid    = (state_q == DONE);
  assign bus.busy        = (state_q == LOADED) || (state_q == SHIFT);
  assign bus.frame_abort = abort_q;

endmodule

// File: tb/tb_spi_shift_engine.sv
// tb_spi_shift_engine: directed, table-driven bench for spi_shift_engine.
module tb_spi_shift_engine;
  import spi_pkg::*;

  localparam int DW = 16;
  localparam int CW = $clog2(DW + 1);

  logic PCLK    = 1'b0;
  logic PRESETn = 1'b0;
  always #5 PCLK = ~PCLK;

  spi_shift_engine_if #(.DATA_W(DW), .CNT_W(CW)) bus();

  spi_shift_engine #(.DATA_W(DW), .CNT_W(CW)) dut (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .bus     (bus.slave)
  );

  typedef struct {
    logic [4:0]  flen;
    int unsigned L;
    logic        lsb;
    logic        cpha;
    logic        cpol;
    logic [15:0] dmosi;
    logic [15:0] miso_w;
    logic [15:0] exp_mosi;
    logic [15:0] exp_miso;
    bit          inject;
    bit          done_load;
  } vec_t;

  vec_t        vecs [8];
  int unsigned checks    = 0;
  int unsigned errors    = 0;
  int unsigned rx_cnt    = 0;
  int unsigned abort_cnt = 0;

  always @(posedge PCLK) begin
    if (bus.rx_valid)    rx_cnt    <= rx_cnt + 1;
    if (bus.frame_abort) abort_cnt <= abort_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clr_strobes();
    bus.flag_high  = 1'b0;
    bus.flag_low   = 1'b0;
    bus.flags_high = 1'b0;
    bus.flags_low  = 1'b0;
  endtask

  // One-cycle strobe: hi picks the *_high pair, smp picks sample vs shift.
  task automatic pulse(input logic hi, input bit smp);
    if (smp) begin
      if (hi) bus.flag_high = 1'b1; else bus.flag_low = 1'b1;
    end else begin
      if (hi) bus.flags_high = 1'b1; else bus.flags_low = 1'b1;
    end
    @(negedge PCLK);
    clr_strobes();
  endtask

  task automatic run_frame(input vec_t v);
    logic [15:0] got;
    int unsigned rx0;
    int unsigned idx;
    logic        sel;
    got = '0;
    rx0 = rx_cnt;
    sel = v.cpha ^ v.cpol;
    @(negedge PCLK);
    bus.ss        = 1'b0;
    bus.lsbfe     = v.lsb;
    bus.cpha      = v.cpha;
    bus.cpol      = v.cpol;
    bus.frame_len = v.flen;
    bus.data_mosi = v.dmosi;
    bus.send_data = 1'b1;
    @(negedge PCLK);
    bus.send_data = 1'b0;
    check("load_busy", 32'(bus.busy), 32'd1);
    @(negedge PCLK);
    for (int unsigned i = 0; i < v.L; i++) begin
      idx = v.lsb ? i : v.L - 1 - i;
      // A shift past the last driven bit must leave mosi alone.
      if (i == v.L - 1) pulse(sel, 1'b0);
      got[idx] = bus.mosi;
      bus.miso = v.miso_w[idx];
      pulse(sel, 1'b1);
      if (i == 3 && v.inject) begin
        bus.data_mosi = 16'hFFFF;
        bus.send_data = 1'b1;
        @(negedge PCLK);
        bus.send_data = 1'b0;
      end
      if (i < v.L - 1) begin
        pulse(sel, 1'b0);
        pulse(~sel, 1'b1);
        pulse(~sel, 1'b0);
      end
    end
    check("done_rx_valid", 32'(bus.rx_valid), 32'd1);
    check("done_data_miso", 32'(bus.data_miso), 32'(v.exp_miso));
    check("done_busy", 32'(bus.busy), 32'd0);
    if (v.done_load) begin
      bus.data_mosi = 16'hFFFF;
      bus.send_data = 1'b1;
    end
    @(negedge PCLK);
    bus.send_data = 1'b0;
    check("idle_busy", 32'(bus.busy), 32'd0);
    check("idle_rx_valid", 32'(bus.rx_valid), 32'd0);
    check("mosi_seq", 32'(got), 32'(v.exp_mosi));
    check("rx_valid_count", rx_cnt - rx0, 32'd1);
  endtask

  // Mode 0, MSB-first, stop in SHIFT with no strobes yet.
  task automatic begin_frame(input logic [15:0] d, input logic [4:0] fl);
    @(negedge PCLK);
    bus.ss        = 1'b0;
    bus.lsbfe     = 1'b0;
    bus.cpha      = 1'b0;
    bus.cpol      = 1'b0;
    bus.frame_len = fl;
    bus.data_mosi = d;
    bus.send_data = 1'b1;
    @(negedge PCLK);
    bus.send_data = 1'b0;
    @(negedge PCLK);
  endtask

  initial begin
    logic [15:0] last_exp;
    int unsigned rx0;
    int unsigned ab0;
    vec_t        lb;

    bus.ss        = 1'b1;
    bus.send_data = 1'b0;
    bus.lsbfe     = 1'b0;
    bus.cpha      = 1'b0;
    bus.cpol      = 1'b0;
    bus.frame_len = '0;
    bus.miso      = 1'b0;
    bus.data_mosi = '0;
`ifdef SPI_SHIFT_LOOPBACK_EN
    bus.loopback  = 1'b0;
`endif
    clr_strobes();

    //          flen   L   lsb cpha cpol dmosi     miso_w    exp_mosi  exp_miso  inj dl
    vecs[0] = '{5'd16, 16, 0,  0,   0,   16'hA55A, 16'h3C0F, 16'hA55A, 16'h3C0F, 0,  0};
    vecs[1] = '{5'd5,  5,  1,  1,   1,   16'h0013, 16'h000D, 16'h0013, 16'h000D, 0,  0};
    vecs[2] = '{5'd0,  16, 1,  1,   0,   16'h8001, 16'hF00F, 16'h8001, 16'hF00F, 0,  0};
    vecs[3] = '{5'd20, 16, 0,  0,   1,   16'h1234, 16'hBEEF, 16'h1234, 16'hBEEF, 0,  0};
    vecs[4] = '{5'd2,  2,  0,  0,   0,   16'hFFFE, 16'h0001, 16'h0002, 16'h0001, 0,  0};
    vecs[5] = '{5'd1,  1,  1,  0,   0,   16'h0001, 16'h0001, 16'h0001, 16'h0001, 0,  0};
    vecs[6] = '{5'd8,  8,  0,  1,   0,   16'h00C3, 16'h005A, 16'h00C3, 16'h005A, 1,  0};
    vecs[7] = '{5'd16, 16, 1,  0,   0,   16'h00FF, 16'h5555, 16'h00FF, 16'h5555, 0,  1};

    repeat (3) @(negedge PCLK);
    check("rst_mosi", 32'(bus.mosi), 32'd0);
    check("rst_data_miso", 32'(bus.data_miso), 32'd0);
    check("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_frame_abort", 32'(bus.frame_abort), 32'd0);
    PRESETn = 1'b1;
    @(negedge PCLK);

    last_exp = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      run_frame(vecs[i]);
      last_exp = vecs[i].exp_miso;
    end

    // ss rises after three samples.
    rx0 = rx_cnt;
    ab0 = abort_cnt;
    begin_frame(16'h0F0F, 5'd16);
    repeat (3) pulse(1'b0, 1'b1);
    bus.ss = 1'b1;
    @(negedge PCLK);
    check("abort_pulse", 32'(bus.frame_abort), 32'd1);
    check("abort_busy", 32'(bus.busy), 32'd0);
    @(negedge PCLK);
    check("abort_pulse_end", 32'(bus.frame_abort), 32'd0);
    check("abort_data_miso", 32'(bus.data_miso), 32'(last_exp));
    check("abort_no_rx_valid", rx_cnt - rx0, 32'd0);
    check("abort_count", abort_cnt - ab0, 32'd1);
    run_frame(vecs[0]);

    // Reset in the middle of a frame.
    ab0 = abort_cnt;
    begin_frame(16'hFFFF, 5'd16);
    repeat (2) pulse(1'b0, 1'b1);
    check("pre_reset_mosi", 32'(bus.mosi), 32'd1);
    check("pre_reset_busy", 32'(bus.busy), 32'd1);
    PRESETn = 1'b0;
    @(negedge PCLK);
    check("mid_rst_mosi", 32'(bus.mosi), 32'd0);
    check("mid_rst_data_miso", 32'(bus.data_miso), 32'd0);
    check("mid_rst_rx_valid", 32'(bus.rx_valid), 32'd0);
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_frame_abort", 32'(bus.frame_abort), 32'd0);
    PRESETn = 1'b1;
    @(negedge PCLK);
    check("mid_rst_no_abort", abort_cnt - ab0, 32'd0);
    run_frame(vecs[1]);

`ifdef SPI_SHIFT_LOOPBACK_EN
    bus.loopback = 1'b1;
    lb = '{5'd16, 16, 0, 0, 0, 16'h1234, 16'hEDCB, 16'h1234, 16'h1234, 0, 0};
    run_frame(lb);
    bus.loopback = 1'b0;
`else
    lb = vecs[3];
    run_frame(lb);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_shift_engine.md
# spi_shift_engine

Parametrised SPI data-path shift engine, successor to the fixed 8-bit SPI shift register. Supports a compile-time maximum word width and a run-time frame length. A frame state machine controls each transfer: it counts bits, signals completion with a valid pulse, and detects slave-select aborts. It sits between the APB-side SPI control/status logic, which supplies `send_data` and the configuration bits, and the baud generator, which supplies the edge flags.

## Interface
- `DATA_W`, 16: maximum frame width in bits, ≥2.
- `CNT_W`, `$clog2(DATA_W+1)`: width of the frame-length and bit counters.

Ports:
- `PCLK`  in  1  system clock; all logic on the rising edge.
- `PRESETn`  in  1  reset; one clock; reset is synchronous and active-low.
- `ss`  in  1  slave select, active low.
- `send_data`  in  1  1-cycle load request.
- `lsbfe`  in  1  1 = LSB first, 0 = MSB first.
- `cpha`, `cpol`  in  1 each  SPI mode bits.
- `flag_high`, `flag_low`  in  1 each  sample-edge strobes from the baud generator.
- `flags_high`, `flags_low`  in  1 each  shift-edge strobes from the baud generator.
- `frame_len`  in  `CNT_W`  bits per frame; value 0 or >`DATA_W` means `DATA_W`.
- `miso`  in  1  serial input.
- `data_mosi`  in  `DATA_W`  transmit word, right-justified.
- `mosi`  out  1  serial output.
- `data_miso`  out  `DATA_W`  last completed receive word, right-justified, upper bits 0.
- `rx_valid`  out  1  1-cycle pulse when `data_miso` updates.
- `busy`  out  1  high in LOADED and SHIFT.
- `frame_abort`  out  1  1-cycle pulse when `ss` rises mid-frame.

## Operation
- Strobe selection: `sample = (cpha^cpol) ? flag_high : flag_low`; `shift = (cpha^cpol) ? flags_high : flags_low`.
- The effective length `L` is latched from `frame_len` on load and is not sampled again during the frame.
- States:
  - **IDLE**: `send_data` loads `tx_reg` with `data_mosi`, clears `rx_reg`, sets `bit_cnt=0`, latches `L`, drives `mosi` with the first bit (`data_mosi[0]` if `lsbfe`, else `data_mosi[L-1]`), then goes to LOADED.
  - **LOADED**: when `ss` is low, go to SHIFT. Strobes are ignored in this state.
  - **SHIFT**:
    - `sample` shifts `miso` into `rx_reg` and increments `bit_cnt`.
    - `shift` drives the next tx bit on `mosi`.
    - When `sample` brings `bit_cnt` to `L`, go to DONE.
  - **DONE**: one cycle. Write `data_miso` right-justified (LSB-first data is aligned down by `DATA_W-L`), pulse `rx_valid`, go to IDLE.
- Simultaneous `sample` and `shift` in one cycle: both act. The sample captures `miso` and the shift updates `mosi`; they do not interact.
- A `shift` strobe after the last bit has been driven leaves `mosi` unchanged.
- `ss` high while in SHIFT or LOADED: go to IDLE, pulse `frame_abort`, leave `data_miso` unchanged, no `rx_valid`.
- `send_data` outside IDLE is ignored. This includes `send_data` arriving in the same cycle as DONE.
- `lsbfe`, `cpha` and `cpol` must be stable while `busy` is high; behaviour is undefined if they change.

## Timing
- Reset values: `mosi=0`, `data_miso=0`, `rx_valid=0`, `busy=0`, `frame_abort=0`, state IDLE, `bit_cnt=0`.
- Reset mid-frame aborts the frame without a `frame_abort` pulse.
- Load: first bit is on `mosi` and `busy=1` in the cycle after `send_data`.
- SHIFT entry: one cycle after `ss` is seen low in LOADED.
- Completion: `rx_valid` and `data_miso` assert one cycle after the L-th `sample` strobe.
- Earliest next load: `busy` falls with `rx_valid`, so the next `send_data` is accepted in the cycle after DONE.
- Abort: `frame_abort` asserts one cycle after `ss` is sampled high.

## Configuration
- `SPI_SHIFT_LOOPBACK_EN` defined: adds input port `loopback` (1 bit). When `loopback=1`, the receive path samples the registered `mosi` instead of `miso`.
- Undefined: no `loopback` port; the receive path always samples `miso`.

## Structure
- Package `spi_pkg` holds the state enum `spi_shift_state_t` (IDLE, LOADED, SHIFT, DONE) and the default width constant `SPI_DATA_W_DEF=16`.
- One sub-module, `spi_bit_counter`: holds `bit_cnt`, the latched `L`, and the combinational `last_bit` output. The frame FSM and the shift registers stay in the top module.

## Test plan
- **Reset:** `DATA_W=16`, assert `PRESETn=0` mid-frame → all outputs 0 on the next edge, state IDLE.
- **Full-width MSB-first, mode 0:** `L=16`, `data_mosi=16'hA55A`, `miso` driven with `16'h3C0F` MSB first → `mosi` sequence 1010010101011010, `data_miso=16'h3C0F`, exactly one `rx_valid`.
- **Short LSB-first, mode 3:** `frame_len=5`, `data_mosi=16'h0013` → `mosi` sequence 1,1,0,0,1. `miso` bits 1,0,1,1,0 → `data_miso=16'h000D`.
- **Abort:** raise `ss` after 3 samples → one `frame_abort` pulse, no `rx_valid`, `data_miso` keeps its previous value, a following `send_data` is accepted.
- **Busy rejection:** `send_data` with `16'hFFFF` while SHIFT → transmitted bits unchanged, frame completes normally.
- **Loopback** (macro defined): `loopback=1`, `data_mosi=16'h1234`, `L=16` → `data_miso=16'h1234` regardless of `miso`.
